// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multi-cycle RV32I sequencer: IR opcode,
// memory handshake and ALU flag in; per-state datapath strobes out.
interface multicycle_control_if;
    logic [31:0] instruction_code;
    logic        mem_ready;
    logic        zero;
    logic        PCWrite;
    logic        IRWrite;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;
    logic        illegal_instr;
    logic        mem_timeout;
    logic [3:0]  state;

    modport master (
        input  instruction_code, mem_ready, zero,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_instr, mem_timeout, state
    );

    modport slave (
        output instruction_code, mem_ready, zero,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_instr, mem_timeout, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Registered FSM sequencing fetch/decode/execute/memory/writeback for an RV32I subset,
// with a bounded wait on the shared memory port's ready handshake.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADDR = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_LOADWB  = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC_R  = 4'd6;
    localparam logic [3:0] S_EXEC_I  = 4'd7;
    localparam logic [3:0] S_ALUWB   = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JAL     = 4'd10;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source;
    logic       alu_src_a, illegal, timeout, wait_expired;
    logic [6:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = bus.instruction_code[6:0];
    assign unused_ir_bits = ^bus.instruction_code[31:7];

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        timeout    = 1'b0;
        // Last permitted wait cycle; a ready on this same cycle still completes.
        wait_expired = !bus.mem_ready && (cnt_q == CNT_LAST);

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_expired) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEMADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_LOADWB;
                end else if (wait_expired) begin
                    timeout = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOADWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    timeout = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = bus.zero;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b01;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset kills any in-flight request in the same cycle, not just at the edge.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            pc_source  = 2'b00;
            illegal    = 1'b0;
            timeout    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PCWrite       = pc_write;
    assign bus.IRWrite       = ir_write;
    assign bus.IorD          = iord;
    assign bus.MemRead       = mem_read;
    assign bus.MemWrite      = mem_write;
    assign bus.RegWrite      = reg_write;
    assign bus.MemtoReg      = mem_to_reg;
    assign bus.ALUSrcA       = alu_src_a;
    assign bus.ALUSrcB       = alu_src_b;
    assign bus.ALUOp         = alu_op;
    assign bus.PCSource      = pc_source;
    assign bus.illegal_instr = illegal;
    assign bus.mem_timeout   = timeout;
    assign bus.state         = state_q;
endmodule
